// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - shared types and width helpers for the carry-save accumulator
//
// Purpose: FSM state type and the width helpers used to size the
// accumulator datapath and the operand counter.
package csa_pkg;

   // ACCUM: folding operands into the pair; HOLD: presenting the pair downstream.
   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } csa_state_t;

   // Accumulator width: operand width plus guard bits.
   function automatic int acc_w(input int n, input int guard);
      return n + guard;
   endfunction

   // Counter width able to hold the values 0..max_ops inclusive.
   function automatic int cnt_w(input int max_ops);
      return $clog2(max_ops + 1);
   endfunction

endpackage

// File: rtl/csa_row.sv
// rtl/csa_row.sv - full adder cell and W-bit 3:2 compressor row
//
// csa_fa: one full adder.
//   a, b, c  in   1   addends
//   s        out  1   sum bit
//   co       out  1   carry-out bit
//
// csa_row: W independent full adders with no carry chain between them.
//   a, b, c  in   W   three vectors to compress
//   s        out  W   bitwise sum
//   co       out  W   bitwise carry, not yet shifted (the caller weights it by 2)
module csa_fa (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ c;
   assign co = (a & b) | (a & c) | (b & c);

endmodule

module csa_row #(
   parameter int W = 12
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   output logic [W-1:0] s,
   output logic [W-1:0] co
);

   for (genvar i = 0; i < W; i++) begin : g_fa
      csa_fa u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .c  (c[i]),
         .s  (s[i]),
         .co (co[i])
      );
   end

endmodule

// File: rtl/ripple_adder.sv
// rtl/ripple_adder.sv - W-bit ripple-carry adder resolving a sum/carry pair
//
// Purpose: downstream stage that turns the redundant pair into a binary value.
//   a, b   in   W   addends
//   s      out  W   a + b modulo 2^W
//   cout   out  1   carry out of the top bit
module ripple_adder #(
   parameter int W = 12
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] s,
   output logic         cout
);

   logic [W:0] c;

   assign c[0] = 1'b0;

   for (genvar i = 0; i < W; i++) begin : g_bit
      csa_fa u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .c  (c[i]),
         .s  (s[i]),
         .co (c[i+1])
      );
   end

   assign cout = c[W];

endmodule

// File: rtl/csa_accumulator.sv
// rtl/csa_accumulator.sv - multi-operand carry-save accumulator with group handshake
//
// Purpose: folds a stream of N-bit unsigned operands into a redundant sum/carry
// pair, one 3:2 compressor row per accepted operand, and presents the pair to a
// downstream ripple adder when the group closes (in_last or MAX_OPS reached).
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   in_valid   in   1       operand valid
//   in_ready   out  1       high in ACCUM
//   in_data    in   N       operand, zero-extended to ACC_W
//   in_last    in   1       accepted operand closes the group
//   out_valid  out  1       high in HOLD
//   out_ready  in   1       downstream takes the pair
//   out_sum    out  ACC_W   redundant sum vector
//   out_carry  out  ACC_W   redundant carry vector, already weighted by 2
//   out_count  out  CNT_W   operands in the group
//   out_ovf    out  1       group force-closed at MAX_OPS without in_last
module csa_accumulator
   import csa_pkg::*;
#(
   parameter  int N       = 8,
   parameter  int GUARD   = 4,
   parameter  int MAX_OPS = 16,
   localparam int ACC_W   = acc_w(N, GUARD),
   localparam int CNT_W   = cnt_w(MAX_OPS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [ACC_W-1:0] out_carry,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf
);

   csa_state_t       state_q, state_d;
   logic [ACC_W-1:0] sum_q,   sum_d;
   logic [ACC_W-1:0] carry_q, carry_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q,   ovf_d;

   logic [ACC_W-1:0] operand;
   logic [ACC_W-1:0] row_s;
   logic [ACC_W-1:0] row_co;
   logic [CNT_W-1:0] count_inc;
   logic             accept;
   logic             full_close;

   assign operand   = {{GUARD{1'b0}}, in_data};
   assign count_inc = count_q + CNT_W'(1);
   assign accept    = (state_q == ACCUM) && in_valid;
   // This accept brings the group to MAX_OPS operands, closing it regardless of in_last.
   assign full_close = (count_inc == CNT_W'(MAX_OPS));

   csa_row #(
      .W (ACC_W)
   ) u_row (
      .a  (sum_q),
      .b  (carry_q),
      .c  (operand),
      .s  (row_s),
      .co (row_co)
   );

   // The top carry bit would weigh 2^ACC_W, so it drops out modulo 2^ACC_W.
   logic unused_co_msb;
   assign unused_co_msb = row_co[ACC_W-1];

   always_comb begin
      state_d = state_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      case (state_q)
         ACCUM: begin
            if (accept) begin
               sum_d   = row_s;
               carry_d = {row_co[ACC_W-2:0], 1'b0};
               count_d = count_inc;
               if (in_last || full_close) begin
                  state_d = HOLD;
                  ovf_d   = full_close && !in_last;
               end
            end
         end
         HOLD: begin
            // Clearing on the handshake edge makes the next group start from zero
            // without an extra idle cycle in ACCUM.
            if (out_ready) begin
               state_d = ACCUM;
               sum_d   = '0;
               carry_d = '0;
               count_d = '0;
               ovf_d   = 1'b0;
            end
         end
         default: begin
            state_d = ACCUM;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ACCUM;
         sum_q   <= '0;
         carry_q <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == ACCUM);
   assign out_valid = (state_q == HOLD);
   assign out_sum   = sum_q;
   assign out_carry = carry_q;
   assign out_count = count_q;
   assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_csa_accumulator.sv
// tb/tb_csa_accumulator.sv - self-checking bench for csa_accumulator
module tb_csa_accumulator;

   localparam int N       = 8;
   localparam int GUARD   = 4;
   localparam int MAX_OPS = 16;
   localparam int ACC_W   = 12;
   localparam int CNT_W   = 5;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [N-1:0]     in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_sum;
   logic [ACC_W-1:0] out_carry;
   logic [CNT_W-1:0] out_count;
   logic             out_ovf;
   logic [ACC_W-1:0] ra_sum;
   logic             ra_cout;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   csa_accumulator #(
      .N       (N),
      .GUARD   (GUARD),
      .MAX_OPS (MAX_OPS)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_carry (out_carry),
      .out_count (out_count),
      .out_ovf   (out_ovf)
   );

   ripple_adder #(
      .W (ACC_W)
   ) u_resolve (
      .a    (out_sum),
      .b    (out_carry),
      .s    (ra_sum),
      .cout (ra_cout)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic send(input logic [N-1:0] d, input logic last, input int gap);
      logic rdy;
      int   waited;
      in_valid = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      waited   = 0;
      forever begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         #1;
         if (rdy) break;
         waited++;
         if (waited > 50) begin
            check("send_timeout", 32'd1, 32'd0);
            break;
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Sends a group, checks the presented pair against the model, stalls, then drains it.
   // val < 0 selects random operands; rnd selects random gaps.
   task automatic run_group(input string tag, input int nops, input bit use_last,
                            input int val, input int stall, input bit rnd);
      int               ref_sum;
      logic [N-1:0]     d;
      logic [ACC_W-1:0] s0, c0;
      int               waited;
      ref_sum = 0;
      for (int i = 0; i < nops; i++) begin
         d = (val < 0) ? N'($urandom_range(0, 255)) : N'(val);
         send(d, use_last && (i == nops - 1), rnd ? int'($urandom_range(0, 3)) : 0);
         ref_sum += int'(d);
      end
      @(negedge clk);
      waited = 0;
      while (!out_valid && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_in_ready"},  32'(in_ready),  32'd0);
      check({tag, "_result"},    32'(ra_sum),    32'(ref_sum % (1 << ACC_W)));
      check({tag, "_count"},     32'(out_count), 32'(nops));
      check({tag, "_ovf"},       32'(out_ovf),   32'((nops == MAX_OPS) && !use_last));
      s0 = out_sum;
      c0 = out_carry;
      repeat (stall) begin
         @(negedge clk);
         check({tag, "_stall_pair"}, {8'd0, out_sum, out_carry}, {8'd0, s0, c0});
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      check({tag, "_drained"}, {30'd0, out_valid, in_ready}, 32'b01);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [ACC_W-1:0] s0, c0;
      int               sum7;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      #12;
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_pair", {8'd0, out_sum, out_carry}, 32'd0);
      check("reset_count_ovf", {26'd0, out_count, out_ovf}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("reset_in_ready", 32'(in_ready), 32'd1);

      run_group("four255", 4, 1'b1, 255, 0, 1'b0);

      send(8'hA5, 1'b1, 0);
      @(negedge clk);
      check("single_valid", 32'(out_valid), 32'd1);
      check("single_sum",   32'(out_sum),   32'h0A5);
      check("single_carry", 32'(out_carry), 32'd0);
      check("single_count", 32'(out_count), 32'd1);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;

      run_group("ovf16", 16, 1'b0, 1, 0, 1'b0);
      run_group("last16", 16, 1'b1, 200, 0, 1'b0);

      // Back-pressure with an operand waiting upstream during HOLD.
      send(8'd10, 1'b0, 0);
      send(8'd20, 1'b1, 0);
      in_valid = 1'b1;
      in_data  = 8'd7;
      in_last  = 1'b1;
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_result", 32'(ra_sum), 32'd30);
      s0 = out_sum;
      c0 = out_carry;
      repeat (5) begin
         @(negedge clk);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_pair_stable", {8'd0, out_sum, out_carry}, {8'd0, s0, c0});
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      check("bp_cleared", {8'd0, out_sum, out_carry}, 32'd0);
      check("bp_cleared_state", {24'd0, out_count, out_valid, in_ready, out_ovf},
            {24'd0, 5'd0, 1'b0, 1'b1, 1'b0});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      @(negedge clk);
      sum7 = 7;
      check("bp_next_valid", 32'(out_valid), 32'd1);
      check("bp_next_result", 32'(ra_sum), 32'(sum7));
      check("bp_next_count", 32'(out_count), 32'd1);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;

      // Asynchronous reset in the middle of a group.
      send(8'd3, 1'b0, 0);
      send(8'd4, 1'b0, 0);
      @(negedge clk);
      check("mid_count", 32'(out_count), 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_out_valid", 32'(out_valid), 32'd0);
      check("async_in_ready", 32'(in_ready), 32'd1);
      check("async_pair", {8'd0, out_sum, out_carry}, 32'd0);
      check("async_count", 32'(out_count), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int g = 0; g < 20; g++) begin
         run_group("rand", int'($urandom_range(1, MAX_OPS)), 1'b1, -1,
                   int'($urandom_range(0, 3)), 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
